mem_dma: RTL and testbench

- Byte-wide block-move / block-fill DMA engine. It is the bus initiator for the 8-bit single-port SPRAM byte port: it drives sel/we/addr/din and consumes dout, which has 1-cycle read latency.
- The 6502 programs it through an 8-byte register window. While a transfer runs, the engine owns the RAM port and holds the CPU via rdy.
- Used for fast memory clears, screen/buffer copies and loader relocation.

---
 rtl/mem_dma.sv | 97 +++++++++
 tb/tb_mem_dma.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_dma.sv
// mem_dma: byte-wide block-move / block-fill DMA engine driving the SPRAM byte port
module mem_dma #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  we,
  input  logic [2:0]            addr,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  rdy,
  output logic                  irq,
  output logic                  mem_sel,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_din,
  input  logic [7:0]            mem_dout
);
  localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2, FILLW = 2'd3;
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  logic [1:0] state;
  logic [ADDR_WIDTH-1:0] src, dst;
  logic [15:0] len, src16, dst16;
  logic [7:0] fill, rdata;
  logic fmode, ien, done, busy, wr;
  assign busy = state != IDLE;
  assign rdy = ~busy;
  assign irq = done & ien;
  assign wr = cs & we & ~busy;
  assign src16 = 16'(src);
  assign dst16 = 16'(dst);
  assign mem_sel = busy;
  assign mem_we = state == WR || state == FILLW;
  assign mem_addr = state == RD ? src : mem_we ? dst : '0;
  assign mem_din = state == WR ? mem_dout : state == FILLW ? fill : 8'h00;
  always_comb begin
    rdata = 8'h00;
    case (addr)
      3'd0: rdata = src16[7:0];
      3'd1: rdata = src16[15:8];
      3'd2: rdata = dst16[7:0];
      3'd3: rdata = dst16[15:8];
      3'd4: rdata = len[7:0];
      3'd5: rdata = len[15:8];
      3'd6: rdata = {4'b0, fmode, ien, done, busy};
      default: rdata = fill;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      src   <= '0;
      dst   <= '0;
      len   <= '0;
      fill  <= '0;
      fmode <= 1'b0;
      ien   <= 1'b0;
      done  <= 1'b0;
      dout  <= '0;
    end else begin
      if (cs & ~we) dout <= rdata;
      if (wr)
        case (addr)
          3'd0: src <= ADDR_WIDTH'({src16[15:8], din});
          3'd1: src <= ADDR_WIDTH'({din, src16[7:0]});
          3'd2: dst <= ADDR_WIDTH'({dst16[15:8], din});
          3'd3: dst <= ADDR_WIDTH'({din, dst16[7:0]});
          3'd4: len <= {len[15:8], din};
          3'd5: len <= {din, len[7:0]};
          3'd6: begin
            // a zero-length START completes immediately without touching RAM
            done  <= din[0] && len == 16'd0;
            fmode <= din[1];
            ien   <= din[2];
            if (din[0] && len != 16'd0) state <= din[1] ? FILLW : RD;
          end
          default: fill <= din;
        endcase
      case (state)
        RD: begin
          src   <= src + ONE;
          state <= WR;
        end
        WR, FILLW: begin
          dst <= dst + ONE;
          len <= len - 16'd1;
          if (len == 16'd1) begin
            state <= IDLE;
            done  <= 1'b1;
          end else state <= state == WR ? RD : FILLW;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: directed checks of mem_dma fill, copy, wrap, zero length, irq and reset abort
module tb_mem_dma;
  logic clk = 1'b0, reset, cs, we;
  logic [2:0] addr;
  logic [7:0] din, dout, mem_din, mem_dout, rd_q, pl_d, rv;
  logic rdy, irq, mem_sel, mem_we, pl_en;
  logic [14:0] mem_addr, pl_a;
  logic [7:0] ram [0:32767];
  logic [14:0] wa [0:255];
  logic [7:0] wd [0:255];
  int wcy [0:255];
  int cyc = 0, wn = 0, sel_n = 0, busy_n = 0;
  int n_cmp = 0, n_bad = 0;
  int w0, s0, b0;

  mem_dma dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr), .din(din), .dout(dout),
    .rdy(rdy), .irq(irq), .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;
  assign mem_dout = rd_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) ram[pl_a] <= pl_d;
    else if (mem_sel && mem_we) ram[mem_addr] <= mem_din;
    rd_q <= ram[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_sel) sel_n <= sel_n + 1;
    if (!rdy) busy_n <= busy_n + 1;
    if (mem_sel && mem_we && wn < 256) begin
      wa[wn]  <= mem_addr;
      wd[wn]  <= mem_din;
      wcy[wn] <= cyc;
      wn      <= wn + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0;
    d = dout;
  endtask

  task automatic preload(input logic [14:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && !rdy; i++) @(negedge clk);
    chk(tag, rdy, 1);
    @(negedge clk);
  endtask

  task automatic snap();
    w0 = wn; s0 = sel_n; b0 = busy_n;
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; din = '0;
    pl_en = 1'b0; pl_a = '0; pl_d = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy, 1);
    chk("rst_irq", irq, 0);
    chk("rst_sel", {mem_sel, mem_we}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", mem_din, 0);
    chk("rst_dout", dout, 0);
    reset = 1'b0;
    @(negedge clk);

    // fill A5 into 0x0100..0x0103
    wr_reg(7, 8'hA5); wr_reg(2, 8'h00); wr_reg(3, 8'h01); wr_reg(4, 8'h04); wr_reg(5, 8'h00);
    snap();
    wr_reg(6, 8'h03);
    wait_idle("fill_end");
    chk("fill_busy", busy_n - b0, 4);
    chk("fill_nwr", wn - w0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("fill_wa", wa[w0+i], 15'h0100 + 15'(i));
      chk("fill_wd", wd[w0+i], 8'hA5);
    end
    chk("fill_span", wcy[w0+3] - wcy[w0], 3);
    rd_reg(6, rv); chk("fill_stat", rv, 8'h0A);
    rd_reg(2, rv); chk("fill_dstl", rv, 8'h04);
    rd_reg(3, rv); chk("fill_dsth", rv, 8'h01);
    rd_reg(4, rv); chk("fill_len", rv, 8'h00);

    // copy 11,22,33 from 0x0010 to 0x0200
    preload(15'h0010, 8'h11); preload(15'h0011, 8'h22); preload(15'h0012, 8'h33);
    wr_reg(0, 8'h10); wr_reg(1, 8'h00); wr_reg(2, 8'h00); wr_reg(3, 8'h02); wr_reg(4, 8'h03);
    snap();
    wr_reg(6, 8'h01);
    wait_idle("copy_end");
    chk("copy_busy", busy_n - b0, 6);
    chk("copy_sel", sel_n - s0, 6);
    chk("copy_nwr", wn - w0, 3);
    chk("copy_gap", wcy[w0+1] - wcy[w0], 2);
    chk("copy_wa2", wa[w0+2], 15'h0202);
    chk("copy_ram0", ram[15'h0200], 8'h11);
    chk("copy_ram1", ram[15'h0201], 8'h22);
    chk("copy_ram2", ram[15'h0202], 8'h33);
    rd_reg(0, rv); chk("copy_srcl", rv, 8'h13);
    rd_reg(1, rv); chk("copy_srch", rv, 8'h00);
    rd_reg(6, rv); chk("copy_stat", rv, 8'h02);

    // fill across the top of the address space
    wr_reg(7, 8'h5A); wr_reg(2, 8'hFE); wr_reg(3, 8'h7F); wr_reg(4, 8'h03);
    snap();
    wr_reg(6, 8'h03);
    wait_idle("wrap_end");
    chk("wrap_wa0", wa[w0], 15'h7FFE);
    chk("wrap_wa1", wa[w0+1], 15'h7FFF);
    chk("wrap_wa2", wa[w0+2], 15'h0000);
    chk("wrap_ram", ram[15'h0000], 8'h5A);
    rd_reg(2, rv); chk("wrap_dstl", rv, 8'h01);
    rd_reg(3, rv); chk("wrap_dsth", rv, 8'h00);

    // zero length start: done at once, no RAM cycle, rdy stays high
    wr_reg(4, 8'h00); wr_reg(5, 8'h00);
    snap();
    wr_reg(6, 8'h05);
    chk("len0_irq", irq, 1);
    repeat (3) @(negedge clk);
    chk("len0_sel", sel_n - s0, 0);
    chk("len0_busy", busy_n - b0, 0);
    rd_reg(6, rv); chk("len0_stat", rv, 8'h06);
    wr_reg(6, 8'h04);
    chk("ien_clr_done", irq, 0);
    rd_reg(6, rv); chk("ien_stat", rv, 8'h04);

    // irq fill with writes attempted while busy
    wr_reg(7, 8'h3C); wr_reg(2, 8'h00); wr_reg(3, 8'h03); wr_reg(4, 8'h02);
    snap();
    wr_reg(6, 8'h07);
    chk("irq_c1", irq, 0);
    wr_reg(4, 8'h09);
    chk("irq_c2", irq, 0);
    wr_reg(6, 8'h01);
    chk("irq_rise", irq, 1);
    repeat (4) @(negedge clk);
    chk("irq_nwr", wn - w0, 2);
    chk("irq_wa1", wa[w0+1], 15'h0301);
    rd_reg(4, rv); chk("irq_len", rv, 8'h00);
    rd_reg(6, rv); chk("irq_stat", rv, 8'h0E);
    wr_reg(6, 8'h00);
    chk("irq_clr", irq, 0);

    // reset after the third RAM cycle of an 8 byte copy
    for (int i = 0; i < 8; i++) preload(15'h0020 + 15'(i), 8'h80 + 8'(i));
    wr_reg(0, 8'h20); wr_reg(2, 8'h00); wr_reg(3, 8'h04); wr_reg(4, 8'h08);
    snap();
    wr_reg(6, 8'h01);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rdy", rdy, 1);
    chk("abort_sel", mem_sel, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_nsel", sel_n - s0, 3);
    chk("abort_nwr", wn - w0, 1);
    chk("abort_ram", ram[15'h0400], 8'h80);
    for (int i = 0; i < 8; i++) begin
      rd_reg(3'(i), rv);
      chk("abort_reg", rv, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
